// File: rtl/sys_rx_cmd_ctrl_if.sv
// Purpose: bundles the UART-RX, register-file and UART-TX signals of the command controller.
// Latency: none (wiring only).
// Backpressure: TX_BUSY is the only stall input; RX bytes and RF read data are unthrottled pulses.
interface sys_rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VALID;
    logic                  RX_FRM_ERR;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [DATA_WIDTH-1:0] RF_RdData;
    logic                  RF_RdData_Valid;
    logic                  TX_BUSY;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VALID;
    logic                  CMD_ERR;

    // Controller side: consumes RX bytes and RF read data, drives RF strobes and TX requests.
    modport master (
        input  RX_P_DATA, RX_D_VALID, RX_FRM_ERR, RF_RdData, RF_RdData_Valid, TX_BUSY,
        output RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TX_D_VALID, CMD_ERR
    );

    // Environment side: UART receiver, register file and UART transmitter.
    modport slave (
        output RX_P_DATA, RX_D_VALID, RX_FRM_ERR, RF_RdData, RF_RdData_Valid, TX_BUSY,
        input  RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TX_D_VALID, CMD_ERR
    );
endinterface

// File: rtl/sys_rx_cmd_ctrl.sv
// Purpose: decodes 0xAA (write) / 0xBB (read) register-file command frames from UART RX bytes.
// Latency: RF strobe 1 cycle after the last command byte; TX request 1 cycle after TX_BUSY is seen low.
// Backpressure: waits indefinitely in TX_SEND while TX_BUSY=1; RX bytes arriving while busy are dropped.
module sys_rx_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    sys_rx_cmd_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'('hBB);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
    } state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_nxt;
    logic [DATA_WIDTH-1:0] tx_dat_q, tx_dat_nxt;
    logic                  wr_en_q, wr_en_nxt;
    logic                  rd_en_q, rd_en_nxt;
    logic                  tx_vld_q, tx_vld_nxt;
    logic                  err_q, err_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  addr_ok;

    // An address byte is legal only when every bit above the RF address width is zero.
    assign addr_ok = ~|bus.RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

    // Next-state decode; all outputs are computed here and registered below.
    always_comb begin
        state_nxt  = state_q;
        addr_nxt   = addr_q;
        wr_dat_nxt = wr_dat_q;
        tx_dat_nxt = tx_dat_q;
        wr_en_nxt  = 1'b0;
        rd_en_nxt  = 1'b0;
        tx_vld_nxt = 1'b0;
        err_nxt    = 1'b0;
        cnt_nxt    = cnt_q;
        case (state_q)
            IDLE: begin
                // Unknown opcodes and framing errors are silently ignored here.
                if (bus.RX_D_VALID) begin
                    if (bus.RX_P_DATA == CMD_WR)      state_nxt = WR_ADDR;
                    else if (bus.RX_P_DATA == CMD_RD) state_nxt = RD_ADDR;
                end
            end
            WR_ADDR, RD_ADDR: begin
                // A framing error beats a coincident byte.
                if (bus.RX_FRM_ERR) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.RX_D_VALID) begin
                    if (!addr_ok) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        if (state_q == WR_ADDR) begin
                            state_nxt = WR_DATA;
                        end else begin
                            // Count from the RdEn cycle so the timeout is measured from the strobe.
                            rd_en_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = RD_EXEC;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (bus.RX_FRM_ERR) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.RX_D_VALID) begin
                    wr_dat_nxt = bus.RX_P_DATA;
                    wr_en_nxt  = 1'b1;
                    state_nxt  = WR_EXEC;
                end
            end
            WR_EXEC: state_nxt = IDLE;
            RD_EXEC: begin
                cnt_nxt   = cnt_q + CNT_W'(1);
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Read data wins over a timeout in the same cycle.
                if (bus.RF_RdData_Valid) begin
                    tx_dat_nxt = bus.RF_RdData;
                    state_nxt  = TX_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            TX_SEND: begin
                if (!bus.TX_BUSY) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and output registers; reset drops any partial command and pending strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_dat_q <= '0;
            tx_dat_q <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_vld_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            addr_q   <= addr_nxt;
            wr_dat_q <= wr_dat_nxt;
            tx_dat_q <= tx_dat_nxt;
            wr_en_q  <= wr_en_nxt;
            rd_en_q  <= rd_en_nxt;
            tx_vld_q <= tx_vld_nxt;
            err_q    <= err_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

    assign bus.RF_Address = addr_q;
    assign bus.RF_WrData  = wr_dat_q;
    assign bus.RF_WrEn    = wr_en_q;
    assign bus.RF_RdEn    = rd_en_q;
    assign bus.TX_P_DATA  = tx_dat_q;
    assign bus.TX_D_VALID = tx_vld_q;
    assign bus.CMD_ERR    = err_q;
endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// Purpose: scoreboard bench for sys_rx_cmd_ctrl with a reactive register-file model.
// Latency: expected events carry the exact cycle in which they must appear.
// Backpressure: TX_BUSY is held for chosen spans to stall the transmit request.
module tb_sys_rx_cmd_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_TX  = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int kind;
        int at;
        int addr;
        int data;
    } ev_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sys_rx_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sys_rx_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;
    int       rd_delay = 0;
    ev_t      exp_q[$];
    logic [7:0] rf_mem [16];
    logic [7:0] ref_mem [16];
    logic [3:0] rsp_addr;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void push(input int kind, input int at, input int addr, input int data);
        ev_t e;
        e.kind = kind; e.at = at; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input int kind, input int addr, input int data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_cycle", cyc, e.at);
        if (kind == EV_WR || kind == EV_RD) check("ev_addr", addr, e.addr);
        if (kind == EV_WR || kind == EV_TX) check("ev_data", data, e.data);
    endfunction

    // Monitor: every strobe the DUT raises is matched against the scoreboard head.
    always @(negedge CLK) begin
        if (bus.RF_WrEn === 1'b1 && bus.RF_RdEn === 1'b1)
            check("wr_rd_exclusive", 1, 0);
        if (bus.RF_WrEn === 1'b1)    observe(EV_WR, int'(bus.RF_Address), int'(bus.RF_WrData));
        if (bus.RF_RdEn === 1'b1)    observe(EV_RD, int'(bus.RF_Address), 0);
        if (bus.TX_D_VALID === 1'b1) observe(EV_TX, 0, int'(bus.TX_P_DATA));
        if (bus.CMD_ERR === 1'b1)    observe(EV_ERR, 0, 0);
    end

    // Register-file storage: written whenever the DUT strobes RF_WrEn.
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 17 + 3);
        forever begin
            @(negedge CLK);
            if (bus.RF_WrEn === 1'b1) rf_mem[bus.RF_Address] = bus.RF_WrData;
        end
    end

    // Register-file read port: answers each RF_RdEn after rd_delay extra cycles.
    initial begin
        bus.RF_RdData_Valid = 1'b0;
        bus.RF_RdData       = '0;
        forever begin
            @(negedge CLK);
            if (bus.RF_RdEn === 1'b1) begin
                rsp_addr = bus.RF_Address;
                repeat (rd_delay + 1) @(posedge CLK);
                #1;
                bus.RF_RdData       = rf_mem[rsp_addr];
                bus.RF_RdData_Valid = 1'b1;
                @(posedge CLK);
                #1;
                bus.RF_RdData_Valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // One RX pulse; c returns the cycle in which it was presented.
    task automatic send(input logic [7:0] b, input logic vld, input logic frm, output int c);
        tick();
        bus.RX_P_DATA  = b;
        bus.RX_D_VALID = vld;
        bus.RX_FRM_ERR = frm;
        c = cyc;
        tick();
        bus.RX_D_VALID = 1'b0;
        bus.RX_FRM_ERR = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_RF_Address"}, 32'(bus.RF_Address), 0);
        check({tag, "_RF_WrData"},  32'(bus.RF_WrData), 0);
        check({tag, "_RF_WrEn"},    32'(bus.RF_WrEn), 0);
        check({tag, "_RF_RdEn"},    32'(bus.RF_RdEn), 0);
        check({tag, "_TX_P_DATA"},  32'(bus.TX_P_DATA), 0);
        check({tag, "_TX_D_VALID"}, 32'(bus.TX_D_VALID), 0);
        check({tag, "_CMD_ERR"},    32'(bus.CMD_ERR), 0);
    endtask

    task automatic do_write(input int a, input int d);
        int c;
        send(8'hAA, 1'b1, 1'b0, c);
        send(8'(a), 1'b1, 1'b0, c);
        send(8'(d), 1'b1, 1'b0, c);
        push(EV_WR, c + 1, a, d);
        ref_mem[a] = 8'(d);
        wait_until(c + 2);
    endtask

    // Read: response d cycles into RD_WAIT, TX_BUSY held busy cycles past TX_SEND entry.
    task automatic do_read(input int a, input int d, input int busy, input bit inject);
        int c, v, f, dummy;
        rd_delay    = d;
        bus.TX_BUSY = (busy > 0);
        send(8'hBB, 1'b1, 1'b0, c);
        send(8'(a), 1'b1, 1'b0, c);
        push(EV_RD, c + 1, a, 0);
        v = c + 2 + d;
        if (busy == 0) push(EV_TX, v + 2, 0, int'(ref_mem[a]));
        if (inject) send(8'hAA, 1'b1, 1'b0, dummy);
        if (busy > 0) begin
            f = v + 1 + busy;
            wait_until(f);
            bus.TX_BUSY = 1'b0;
            push(EV_TX, f + 1, 0, int'(ref_mem[a]));
            wait_until(f + 2);
        end else begin
            wait_until(v + 3);
        end
    endtask

    task automatic do_timeout(input int a);
        int c;
        rd_delay = 20;
        send(8'hBB, 1'b1, 1'b0, c);
        send(8'(a), 1'b1, 1'b0, c);
        push(EV_RD, c + 1, a, 0);
        push(EV_ERR, c + 1 + TO, 0, 0);
        wait_until(c + 2 + 20 + 3);
    endtask

    task automatic do_bad_addr(input logic [7:0] cmd, input logic [7:0] a8);
        int c;
        send(cmd, 1'b1, 1'b0, c);
        send(a8, 1'b1, 1'b0, c);
        push(EV_ERR, c + 1, 0, 0);
    endtask

    // Framing error in WR_ADDR (0), WR_DATA (1) or RD_ADDR (2).
    task automatic do_frm(input int where, input logic [7:0] b, input logic vld);
        int c;
        send((where == 2) ? 8'hBB : 8'hAA, 1'b1, 1'b0, c);
        if (where == 1) send(8'($urandom_range(0, 15)), 1'b1, 1'b0, c);
        send(b, vld, 1'b1, c);
        push(EV_ERR, c + 1, 0, 0);
    endtask

    initial begin
        int c;
        logic [7:0] g;
        RST = 1'b1;
        bus.RX_P_DATA  = '0;
        bus.RX_D_VALID = 1'b0;
        bus.RX_FRM_ERR = 1'b0;
        bus.TX_BUSY    = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17 + 3);
        repeat (3) tick();
        RST = 1'b0;
        check_outputs_zero("reset");

        // Directed cases.
        do_write(5, 8'hA6);
        do_read(5, 2, 0, 1'b0);
        do_read(5, 2, 10, 1'b0);
        send(8'h12, 1'b1, 1'b0, c);
        send(8'h00, 1'b0, 1'b1, c);
        do_bad_addr(8'hAA, 8'h25);
        do_write(3, 8'h7F);
        do_frm(1, 8'h11, 1'b1);
        do_timeout(2);
        do_read(3, 14, 0, 1'b0);
        do_read(9, 0, 0, 1'b1);

        // Reset in the middle of a write command.
        send(8'hAA, 1'b1, 1'b0, c);
        send(8'h05, 1'b1, 1'b0, c);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_outputs_zero("midrst");
        send(8'hA6, 1'b1, 1'b0, c);
        wait_until(c + 3);
        check_outputs_zero("after_a6");
        do_read(5, 1, 0, 1'b0);

        // Randomized command mix.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0, 1: do_write($urandom_range(0, 15), $urandom_range(0, 255));
                2:    do_read($urandom_range(0, 15), $urandom_range(0, 14),
                              ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : 0,
                              1'($urandom_range(0, 1)));
                3:    do_bad_addr(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB,
                                  {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))});
                4:    do_frm($urandom_range(0, 2), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                5: begin
                    g = 8'($urandom_range(0, 255));
                    while (g == 8'hAA || g == 8'hBB) g = 8'($urandom_range(0, 255));
                    send(g, 1'b1, 1'($urandom_range(0, 1)), c);
                end
                default: do_timeout($urandom_range(0, 15));
            endcase
        end

        repeat (30) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
